// File: rtl/if_stage.sv
// if_stage: instruction fetch with integrated IF/ID register.
//   Fetches one word at a time over a req/gnt/rvalid handshake (a single
//   request in flight), keeps one returned word in a buffer while decode is
//   stalled, and applies MIPS branch semantics: the delay slot is always
//   delivered, and fetch is redirected to the target afterwards.
// Ports:
//   clk, rst              clock; asynchronous active-low reset
//   stall_i               decode stall; holds IF/ID
//   branch_flag_i         taken branch for the instruction in IF/ID
//   branch_addr_i         branch target
//   next_is_delayslot_i   next delivered instruction is a delay slot
//   inst_req_o/addr_o     fetch request and address
//   inst_gnt_i            request accepted
//   inst_rvalid_i/rdata_i returned instruction
//   pc_o, inst_o, is_delayslot_o, id_valid_o   IF/ID register outputs
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_addr_i,
  input  logic        next_is_delayslot_i,
  output logic        inst_req_o,
  output logic [31:0] inst_addr_o,
  input  logic        inst_gnt_i,
  input  logic        inst_rvalid_i,
  input  logic [31:0] inst_rdata_i,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o,
  output logic        is_delayslot_o,
  output logic        id_valid_o
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

  state_t      state;
  logic [31:0] fetch_pc;
  logic [31:0] req_pc;
  logic [31:0] buf_pc;
  logic [31:0] buf_inst;
  logic        redirect_pending;
  logic [31:0] target;

  logic        gnt_acc;
  logic        br_acc;
  logic [31:0] ds_pc;
  logic        redirect_now;
  logic        load_mem;
  logic        load_buf;

  assign gnt_acc  = (state == REQ) && inst_gnt_i;
  assign br_acc   = id_valid_o && !stall_i && branch_flag_i;
  assign ds_pc    = pc_o + 32'd4;
  // Delay slot not yet granted: it must still be fetched, so the redirect
  // is deferred until its grant.
  assign redirect_now = br_acc && (fetch_pc == ds_pc);
  assign load_mem = (state == WAIT) && inst_rvalid_i && !stall_i;
  assign load_buf = (state == HOLD) && !stall_i;

  assign inst_addr_o = fetch_pc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state            <= IDLE;
      inst_req_o       <= 1'b0;
      fetch_pc         <= RESET_PC;
      req_pc           <= RESET_PC;
      buf_pc           <= '0;
      buf_inst         <= NOP_INST;
      redirect_pending <= 1'b0;
      target           <= '0;
      pc_o             <= '0;
      inst_o           <= NOP_INST;
      is_delayslot_o   <= 1'b0;
      id_valid_o       <= 1'b0;
    end else begin
      // handshake FSM; responses outside WAIT are stale and dropped
      case (state)
        IDLE: begin
          state      <= REQ;
          inst_req_o <= 1'b1;
        end
        REQ: if (inst_gnt_i) begin
          state      <= WAIT;
          inst_req_o <= 1'b0;
          req_pc     <= fetch_pc;
        end
        WAIT: if (inst_rvalid_i) begin
          if (stall_i) begin
            state    <= HOLD;
            buf_pc   <= req_pc;
            buf_inst <= inst_rdata_i;
          end else begin
            state      <= REQ;
            inst_req_o <= 1'b1;
          end
        end
        HOLD: if (!stall_i) begin
          state      <= REQ;
          inst_req_o <= 1'b1;
        end
        default: begin
          state      <= IDLE;
          inst_req_o <= 1'b0;
        end
      endcase

      // next fetch address / deferred redirect
      if (gnt_acc) begin
        if (redirect_pending)  fetch_pc <= target;
        else if (redirect_now) fetch_pc <= branch_addr_i;
        else                   fetch_pc <= fetch_pc + 32'd4;
        redirect_pending <= 1'b0;
      end else if (redirect_now) begin
        redirect_pending <= 1'b1;
        target           <= branch_addr_i;
      end else if (br_acc) begin
        // delay slot already in flight or buffered
        fetch_pc <= branch_addr_i;
      end

      // IF/ID register; fresh data bypasses the buffer on stall release
      if (!stall_i) begin
        if (load_mem) begin
          pc_o           <= req_pc;
          inst_o         <= inst_rdata_i;
          is_delayslot_o <= next_is_delayslot_i;
          id_valid_o     <= 1'b1;
        end else if (load_buf) begin
          pc_o           <= buf_pc;
          inst_o         <= buf_inst;
          is_delayslot_o <= next_is_delayslot_i;
          id_valid_o     <= 1'b1;
        end else begin
          inst_o         <= NOP_INST;
          is_delayslot_o <= 1'b0;
          id_valid_o     <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed tests for if_stage with a zero-wait memory model
// (gnt in the request cycle, rvalid one cycle later). Data word for an
// address a is a ^ 5A5A5A5A unless overridden.
module tb_if_stage;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall_i = 1'b0;
  logic        branch_flag_i = 1'b0;
  logic [31:0] branch_addr_i = '0;
  logic        next_is_delayslot_i = 1'b0;
  logic        inst_req_o;
  logic [31:0] inst_addr_o;
  logic        inst_gnt_i;
  logic        inst_rvalid_i;
  logic [31:0] inst_rdata_i;
  logic [31:0] pc_o;
  logic [31:0] inst_o;
  logic        is_delayslot_o;
  logic        id_valid_o;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  bit          gnt_en = 1'b1;
  bit          rv_en = 1'b1;
  bit          resp_pend = 1'b0;
  logic [31:0] resp_addr = '0;
  bit          ovr_on = 1'b0;
  logic [31:0] ovr_addr = '0;
  logic [31:0] ovr_data = '0;
  logic [31:0] req_log[$];
  int          req_cyc[$];

  if_stage dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .branch_flag_i(branch_flag_i),
    .branch_addr_i(branch_addr_i), .next_is_delayslot_i(next_is_delayslot_i),
    .inst_req_o(inst_req_o), .inst_addr_o(inst_addr_o), .inst_gnt_i(inst_gnt_i),
    .inst_rvalid_i(inst_rvalid_i), .inst_rdata_i(inst_rdata_i), .pc_o(pc_o),
    .inst_o(inst_o), .is_delayslot_o(is_delayslot_o), .id_valid_o(id_valid_o)
  );

  initial forever #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc++; end

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return a ^ 32'h5A5A_5A5A;
  endfunction

  // memory model: acts 1 time unit after the falling edge so the test
  // process can change gnt_en / rv_en on the edge itself
  initial begin
    inst_gnt_i = 1'b0; inst_rvalid_i = 1'b0; inst_rdata_i = '0;
    forever begin
      @(negedge clk); #1;
      inst_rvalid_i = 1'b0;
      if (resp_pend && rv_en) begin
        inst_rvalid_i = 1'b1;
        inst_rdata_i  = (ovr_on && resp_addr == ovr_addr) ? ovr_data : inst_of(resp_addr);
        resp_pend     = 1'b0;
      end
      inst_gnt_i = inst_req_o && gnt_en && !resp_pend;
      if (inst_gnt_i) begin
        resp_pend = 1'b1;
        resp_addr = inst_addr_o;
        req_log.push_back(inst_addr_o);
        req_cyc.push_back(cyc);
      end
    end
  end

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (id_valid_o) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset;
    @(negedge clk); @(negedge clk);
    checks++; if (inst_req_o !== 1'b0) begin errors++; $display("FAIL rst_req got %b exp 0", inst_req_o); end
    checks++; if (inst_addr_o !== 32'hBFC0_0000) begin errors++; $display("FAIL rst_addr got %h exp bfc00000", inst_addr_o); end
    checks++; if (pc_o !== 32'h0) begin errors++; $display("FAIL rst_pc got %h exp 0", pc_o); end
    checks++; if (inst_o !== 32'h0) begin errors++; $display("FAIL rst_inst got %h exp 0", inst_o); end
    checks++; if (is_delayslot_o !== 1'b0) begin errors++; $display("FAIL rst_ds got %b exp 0", is_delayslot_o); end
    checks++; if (id_valid_o !== 1'b0) begin errors++; $display("FAIL rst_vld got %b exp 0", id_valid_o); end
  endtask

  task automatic test_sequential;
    bit exp_req [7] = '{1, 0, 1, 0, 1, 0, 1};
    int exp_aof [7] = '{0, 0, 4, 0, 8, 0, 12};
    bit exp_vld [7] = '{0, 0, 1, 0, 1, 0, 1};
    int exp_pof [7] = '{-1, -1, 0, 0, 4, 4, 8};
    logic [31:0] ea, ep;
    rst = 1'b1;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      ea = 32'hBFC0_0000 + exp_aof[k];
      ep = (exp_pof[k] < 0) ? 32'h0 : 32'hBFC0_0000 + exp_pof[k];
      checks++; if (inst_req_o !== exp_req[k]) begin errors++; $display("FAIL seq_req[%0d] got %b exp %b", k, inst_req_o, exp_req[k]); end
      if (exp_req[k]) begin
        checks++; if (inst_addr_o !== ea) begin errors++; $display("FAIL seq_addr[%0d] got %h exp %h", k, inst_addr_o, ea); end
      end
      checks++; if (id_valid_o !== exp_vld[k]) begin errors++; $display("FAIL seq_vld[%0d] got %b exp %b", k, id_valid_o, exp_vld[k]); end
      checks++; if (pc_o !== ep) begin errors++; $display("FAIL seq_pc[%0d] got %h exp %h", k, pc_o, ep); end
      checks++; if (inst_o !== (exp_vld[k] ? inst_of(ep) : 32'h0)) begin errors++; $display("FAIL seq_inst[%0d] got %h exp %h", k, inst_o, exp_vld[k] ? inst_of(ep) : 32'h0); end
    end
    checks++; if (req_cyc.size() < 3 || req_cyc[1] - req_cyc[0] != 2 || req_cyc[2] - req_cyc[1] != 2) begin errors++; $display("FAIL seq_rate got %0d grants exp 2-cycle spacing", req_cyc.size()); end
  endtask

  // entered at a cycle where IF/ID = BFC00008 and BFC0000C is being granted
  task automatic test_stall;
    int sz;
    sz = req_log.size();
    ovr_on = 1'b1; ovr_addr = 32'hBFC0_000C; ovr_data = 32'h3401_0005;
    stall_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++; if (inst_req_o !== 1'b0) begin errors++; $display("FAIL stall_req[%0d] got %b exp 0", k, inst_req_o); end
      checks++; if (id_valid_o !== 1'b1 || pc_o !== 32'hBFC0_0008) begin errors++; $display("FAIL stall_hold[%0d] got %b/%h exp 1/bfc00008", k, id_valid_o, pc_o); end
    end
    checks++; if (req_log.size() != sz + 1) begin errors++; $display("FAIL stall_nreq got %0d exp %0d", req_log.size(), sz + 1); end
    stall_i = 1'b0;
    @(negedge clk);
    checks++; if (pc_o !== 32'hBFC0_000C || inst_o !== 32'h3401_0005) begin errors++; $display("FAIL stall_release got %h/%h exp bfc0000c/34010005", pc_o, inst_o); end
    checks++; if (inst_req_o !== 1'b1 || inst_addr_o !== 32'hBFC0_0010) begin errors++; $display("FAIL stall_resume got %b/%h exp 1/bfc00010", inst_req_o, inst_addr_o); end
    ovr_on = 1'b0;
  endtask

  // branch from BFC0000C to 0x100, then from 0x100 to 0x200 with the grant
  // of the delay slot held back one cycle
  task automatic test_branch_unfetched;
    bit ok;
    int sz;
    branch_flag_i = 1'b1; branch_addr_i = 32'h100; next_is_delayslot_i = 1'b1;
    @(negedge clk); branch_flag_i = 1'b0;
    wait_valid(ok);
    checks++; if (!ok || pc_o !== 32'hBFC0_0010 || is_delayslot_o !== 1'b1) begin errors++; $display("FAIL br1_ds got %b %h ds=%b exp 1 bfc00010 ds=1", ok, pc_o, is_delayslot_o); end
    next_is_delayslot_i = 1'b0;
    checks++; if (inst_addr_o !== 32'h100) begin errors++; $display("FAIL br1_target got %h exp 100", inst_addr_o); end
    wait_valid(ok);
    checks++; if (!ok || pc_o !== 32'h100 || is_delayslot_o !== 1'b0) begin errors++; $display("FAIL br1_land got %b %h ds=%b exp 1 100 ds=0", ok, pc_o, is_delayslot_o); end
    sz = req_log.size();
    gnt_en = 1'b0;
    branch_flag_i = 1'b1; branch_addr_i = 32'h200; next_is_delayslot_i = 1'b1;
    @(negedge clk); branch_flag_i = 1'b0; gnt_en = 1'b1;
    checks++; if (inst_req_o !== 1'b1 || inst_addr_o !== 32'h104) begin errors++; $display("FAIL br2_dsreq got %b/%h exp 1/104", inst_req_o, inst_addr_o); end
    wait_valid(ok);
    checks++; if (!ok || pc_o !== 32'h104 || is_delayslot_o !== 1'b1 || inst_o !== inst_of(32'h104)) begin errors++; $display("FAIL br2_ds got %b %h ds=%b %h exp 1 104 ds=1 %h", ok, pc_o, is_delayslot_o, inst_o, inst_of(32'h104)); end
    next_is_delayslot_i = 1'b0;
    wait_valid(ok);
    checks++; if (!ok || pc_o !== 32'h200 || is_delayslot_o !== 1'b0) begin errors++; $display("FAIL br2_land got %b %h ds=%b exp 1 200 ds=0", ok, pc_o, is_delayslot_o); end
    checks++; if (req_log.size() < sz + 2 || req_log[sz] !== 32'h104 || req_log[sz+1] !== 32'h200) begin errors++; $display("FAIL br2_fetches got %0d entries exp 104,200", req_log.size() - sz); end
  endtask

  // 0x200 -> 0x100, then a branch at 0x100 while its delay slot is buffered
  task automatic test_branch_buffered;
    bit ok;
    int sz;
    branch_flag_i = 1'b1; branch_addr_i = 32'h100; next_is_delayslot_i = 1'b1;
    @(negedge clk); branch_flag_i = 1'b0;
    wait_valid(ok); next_is_delayslot_i = 1'b0;
    wait_valid(ok);
    checks++; if (!ok || pc_o !== 32'h100) begin errors++; $display("FAIL bb_land got %b %h exp 1 100", ok, pc_o); end
    sz = req_log.size();
    stall_i = 1'b1;
    repeat (3) @(negedge clk);
    stall_i = 1'b0; branch_flag_i = 1'b1; branch_addr_i = 32'h200; next_is_delayslot_i = 1'b1;
    @(negedge clk); branch_flag_i = 1'b0;
    checks++; if (id_valid_o !== 1'b1 || pc_o !== 32'h104 || is_delayslot_o !== 1'b1) begin errors++; $display("FAIL bb_ds got %b %h ds=%b exp 1 104 ds=1", id_valid_o, pc_o, is_delayslot_o); end
    next_is_delayslot_i = 1'b0;
    checks++; if (inst_req_o !== 1'b1 || inst_addr_o !== 32'h200) begin errors++; $display("FAIL bb_nextreq got %b/%h exp 1/200", inst_req_o, inst_addr_o); end
    wait_valid(ok);
    checks++; if (!ok || pc_o !== 32'h200) begin errors++; $display("FAIL bb_target got %b %h exp 1 200", ok, pc_o); end
    checks++; if (req_log.size() < sz + 2 || req_log[sz] !== 32'h104 || req_log[sz+1] !== 32'h200) begin errors++; $display("FAIL bb_fetches got %0d entries exp 104,200", req_log.size() - sz); end
  endtask

  task automatic test_wrap;
    bit ok;
    branch_flag_i = 1'b1; branch_addr_i = 32'hFFFF_FFFC; next_is_delayslot_i = 1'b1;
    @(negedge clk); branch_flag_i = 1'b0;
    wait_valid(ok); next_is_delayslot_i = 1'b0;
    wait_valid(ok);
    checks++; if (!ok || pc_o !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_pc got %b %h exp 1 fffffffc", ok, pc_o); end
    checks++; if (inst_req_o !== 1'b1 || inst_addr_o !== 32'h0) begin errors++; $display("FAIL wrap_addr got %b/%h exp 1/00000000", inst_req_o, inst_addr_o); end
    wait_valid(ok);
    checks++; if (!ok || pc_o !== 32'h0 || inst_o !== inst_of(32'h0)) begin errors++; $display("FAIL wrap_next got %b %h %h exp 1 0 %h", ok, pc_o, inst_o, inst_of(32'h0)); end
  endtask

  task automatic test_reset_in_wait;
    bit ok;
    rv_en = 1'b0;
    @(negedge clk);
    checks++; if (inst_req_o !== 1'b0) begin errors++; $display("FAIL rw_wait got %b exp 0", inst_req_o); end
    rst = 1'b0; #1;
    checks++; if (inst_req_o !== 1'b0 || inst_addr_o !== 32'hBFC0_0000) begin errors++; $display("FAIL rw_fetch got %b/%h exp 0/bfc00000", inst_req_o, inst_addr_o); end
    checks++; if (pc_o !== 32'h0 || inst_o !== 32'h0 || is_delayslot_o !== 1'b0 || id_valid_o !== 1'b0) begin errors++; $display("FAIL rw_ifid got %h %h %b %b exp 0 0 0 0", pc_o, inst_o, is_delayslot_o, id_valid_o); end
    repeat (2) @(negedge clk);
    req_log.delete();
    rst = 1'b1; rv_en = 1'b1;
    wait_valid(ok);
    checks++; if (!ok || pc_o !== 32'hBFC0_0000 || inst_o !== inst_of(32'hBFC0_0000)) begin errors++; $display("FAIL rw_first got %b %h %h exp 1 bfc00000 %h", ok, pc_o, inst_o, inst_of(32'hBFC0_0000)); end
    checks++; if (req_log.size() < 1 || req_log[0] !== 32'hBFC0_0000) begin errors++; $display("FAIL rw_req got %0d entries exp first bfc00000", req_log.size()); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_branch_unfetched();
    test_branch_buffered();
    test_wrap();
    test_reset_in_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
